// File: rtl/mem_arbiter.sv
// Main-memory arbiter: runs I-cache refills and D-cache writeback/refill line transfers
// over one memory port, alternating priority when both caches miss together.
module mem_arbiter #(
    parameter int LINE_WORDS = 4,
    parameter int IDX_W      = 2,
    parameter int ADDR_W     = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              icache_req,
    input  logic [ADDR_W-1:0] icache_addr,
    output logic              icache_fill_we,
    output logic              icache_done,
    input  logic              dcache_req,
    input  logic [ADDR_W-1:0] dcache_addr,
    input  logic              dcache_dirty,
    input  logic [ADDR_W-1:0] dcache_wb_addr,
    input  logic [31:0]       dcache_wb_data,
    output logic              dcache_fill_we,
    output logic              dcache_done,
    output logic [IDX_W-1:0]  fill_idx,
    output logic [31:0]       fill_data,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ack,
    output logic              busy
);
    typedef enum logic [2:0] {IDLE, I_FILL, D_WB, D_FILL, DONE} state_t;

    localparam int OFF_W = IDX_W + 2;
    localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'((1 << OFF_W) - 1);

    state_t            state, state_n;
    logic              owner_d, owner_d_n;
    logic              last_d, last_d_n;
    logic [IDX_W-1:0]  idx, idx_n;
    logic [ADDR_W-1:0] base, base_n;
    logic [ADDR_W-1:0] fill_base, fill_base_n;

    logic in_xfer, last_word, grant_d, grant_i;

    assign in_xfer   = (state == I_FILL) || (state == D_WB) || (state == D_FILL);
    assign last_word = (idx == IDX_W'(LINE_WORDS - 1));
    // D wins a tie unless it was the previous owner
    assign grant_d   = dcache_req && !(icache_req && last_d);
    assign grant_i   = icache_req && !grant_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            owner_d   <= 1'b0;
            last_d    <= 1'b0;
            idx       <= '0;
            base      <= '0;
            fill_base <= '0;
        end else begin
            state     <= state_n;
            owner_d   <= owner_d_n;
            last_d    <= last_d_n;
            idx       <= idx_n;
            base      <= base_n;
            fill_base <= fill_base_n;
        end
    end

    always_comb begin
        state_n     = state;
        owner_d_n   = owner_d;
        last_d_n    = last_d;
        idx_n       = idx;
        base_n      = base;
        fill_base_n = fill_base;
        case (state)
            IDLE: begin
                if (grant_d) begin
                    owner_d_n   = 1'b1;
                    last_d_n    = 1'b1;
                    idx_n       = '0;
                    fill_base_n = dcache_addr & ~OFF_MASK;
                    if (dcache_dirty) begin
                        state_n = D_WB;
                        base_n  = dcache_wb_addr & ~OFF_MASK;
                    end else begin
                        state_n = D_FILL;
                        base_n  = dcache_addr & ~OFF_MASK;
                    end
                end else if (grant_i) begin
                    owner_d_n = 1'b0;
                    last_d_n  = 1'b0;
                    idx_n     = '0;
                    base_n    = icache_addr & ~OFF_MASK;
                    state_n   = I_FILL;
                end
            end
            I_FILL, D_WB, D_FILL: begin
                if (mem_ack) begin
                    idx_n = idx + 1'b1;
                    if (last_word) begin
                        idx_n = '0;
                        // writeback finished: refill the line latched at grant time
                        if (state == D_WB) begin
                            state_n = D_FILL;
                            base_n  = fill_base;
                        end else begin
                            state_n = DONE;
                        end
                    end
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    assign busy           = (state != IDLE);
    assign mem_req        = in_xfer;
    assign mem_we         = (state == D_WB);
    assign mem_addr       = in_xfer ? (base | (ADDR_W'(idx) << 2)) : '0;
    assign mem_wdata      = dcache_wb_data;
    assign fill_idx       = idx;
    assign fill_data      = mem_rdata;
    assign icache_fill_we = (state == I_FILL) && mem_ack;
    assign dcache_fill_we = (state == D_FILL) && mem_ack;
    assign icache_done    = (state == DONE) && !owner_d;
    assign dcache_done    = (state == DONE) && owner_d;
endmodule
